// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_hazard_pkg;

  // Widest register address an entry can hold; narrower addresses are zero-extended.
  localparam int MAX_REG_AW = 8;

  // Forward select value meaning "take the operand from the register file".
  localparam int FWD_REGFILE = 0;

  // Scoreboard stage indices after ID.
  localparam int IDX_EX  = 0;
  localparam int IDX_MEM = 1;
  localparam int IDX_WB  = 2;

  typedef logic [MAX_REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_read;
  } sb_entry_t;

  localparam sb_entry_t SB_INVALID = '0;

  // True when an in-flight entry produces the register a used source reads; r0 never matches.
  function automatic logic src_matches(input sb_entry_t e, input reg_addr_t src, input logic used);
    return used && e.valid && e.reg_write && (e.rd == src) && (src != '0);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_scoreboard.sv
// Shift array of in-flight destination registers, one entry per stage after ID.
module hazard_scoreboard
  import pipe_hazard_pkg::*;
#(
  parameter int DEPTH = 3
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  shift,
  input  logic                  freeze,
  input  logic [DEPTH-2:0]      clear_lo_mask,
  input  sb_entry_t             in_entry,
  output sb_entry_t [DEPTH-1:0] entries
);

  sb_entry_t [DEPTH-1:0] sb_q;

  // Advance entries one stage; a set mask bit squashes the entry leaving that index.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q <= '0;
    end else if (shift && !freeze) begin
      sb_q[0] <= in_entry;
      for (int i = 1; i < DEPTH; i++) begin
        if (clear_lo_mask[i-1]) begin
          sb_q[i] <= SB_INVALID;
        end else begin
          sb_q[i] <= sb_q[i-1];
        end
      end
    end
  end

  assign entries = sb_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline.
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = IDX_WB,
  parameter int BR_STAGE   = IDX_MEM,
  parameter int FWD_W      = $clog2(DEPTH)
)(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      br_taken,
  output logic                      stall_pc,
  output logic                      stall_ifid,
  output logic                      bubble_idex,
  output logic [BR_STAGE+1:0]       flush,
  output logic [NUM_SRC*FWD_W-1:0]  fwd_sel
);

  sb_entry_t [DEPTH-1:0]           entries;
  sb_entry_t                       in_entry;
  logic [DEPTH-2:0]                clear_lo_mask;
  logic [NUM_SRC-1:0][REG_AW-1:0]  ex_src;
  logic [NUM_SRC-1:0]              ex_used;
  logic                            load_use;
  logic                            flush_now;
  logic                            bubble_now;
  logic [NUM_SRC*FWD_W-1:0]        fwd_raw;

  // A taken branch only counts when the pipeline is moving; it beats any load-use stall.
  assign flush_now  = !hold && br_taken;
  assign bubble_now = !hold && !flush_now && load_use;

  // Load-use: an ID source needs a load whose data will not be forwardable next cycle.
  always_comb begin
    load_use = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = IDX_EX; i < DEPTH; i++) begin
        if (i < LOAD_READY - 1 && entries[i].mem_read &&
            src_matches(entries[i], reg_addr_t'(id_src[k*REG_AW +: REG_AW]), id_src_used[k])) begin
          load_use = 1'b1;
        end
      end
    end
  end

  // Per EX source, pick the youngest producer from MEM onward, skipping loads not yet ready.
  always_comb begin
    fwd_raw = {NUM_SRC{FWD_W'(FWD_REGFILE)}};
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = DEPTH - 1; i >= IDX_MEM; i--) begin
        if (!(entries[i].mem_read && i < LOAD_READY) &&
            src_matches(entries[i], reg_addr_t'(ex_src[k]), ex_used[k])) begin
          fwd_raw[k*FWD_W +: FWD_W] = FWD_W'(i);
        end
      end
    end
  end

  // Entry entering EX: squashed on bubble, flush, or an empty ID slot.
  always_comb begin
    in_entry = SB_INVALID;
    if (id_valid && !bubble_now && !flush_now) begin
      in_entry.valid     = 1'b1;
      in_entry.rd        = reg_addr_t'(id_rd);
      in_entry.reg_write = id_reg_write;
      in_entry.mem_read  = id_mem_read;
    end
  end

  // On a flush, everything younger than the branch stage is squashed as it shifts.
  always_comb begin
    clear_lo_mask = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      clear_lo_mask[i] = flush_now && (i < BR_STAGE);
    end
  end

  hazard_scoreboard #(
    .DEPTH(DEPTH)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .shift        (1'b1),
    .freeze       (hold),
    .clear_lo_mask(clear_lo_mask),
    .in_entry     (in_entry),
    .entries      (entries)
  );

  // EX-source latch follows the instruction entering EX; bubble or flush leaves it reading nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_src  <= '0;
      ex_used <= '0;
    end else if (!hold) begin
      if (bubble_now || flush_now) begin
        ex_used <= '0;
      end else begin
        ex_src  <= id_src;
        ex_used <= id_src_used;
      end
    end
  end

  // Output arbitration: hold freezes the front end, and reset silences every control.
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    bubble_idex = 1'b0;
    flush       = '0;
    fwd_sel     = '0;
    if (!reset) begin
      stall_pc    = hold || bubble_now;
      stall_ifid  = hold || bubble_now;
      bubble_idex = bubble_now;
      flush       = {(BR_STAGE+2){flush_now}};
      fwd_sel     = fwd_raw;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed scenarios plus randomized traffic
// compared every cycle against an instruction-level pipeline model.
module tb_pipe_hazard_unit;

  localparam int LOAD_READY = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       hold = 1'b0;
  logic       id_valid = 1'b0;
  logic [9:0] id_src = '0;
  logic [1:0] id_src_used = '0;
  logic [4:0] id_rd = '0;
  logic       id_reg_write = 1'b0;
  logic       id_mem_read = 1'b0;
  logic       br_taken = 1'b0;
  logic       stall_pc;
  logic       stall_ifid;
  logic       bubble_idex;
  logic [2:0] flush;
  logic [3:0] fwd_sel;

  int check_count = 0;
  int pass_count  = 0;
  bit model_ready = 1'b0;

  pipe_hazard_unit #(
    .REG_AW(5), .NUM_SRC(2), .DEPTH(3), .LOAD_READY(2), .BR_STAGE(1), .FWD_W(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hold        (hold),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .id_rd       (id_rd),
    .id_reg_write(id_reg_write),
    .id_mem_read (id_mem_read),
    .br_taken    (br_taken),
    .stall_pc    (stall_pc),
    .stall_ifid  (stall_ifid),
    .bubble_idex (bubble_idex),
    .flush       (flush),
    .fwd_sel     (fwd_sel)
  );

  always #5 clk = ~clk;

  // One whole instruction as the model sees it; mdl[0]=EX, mdl[1]=MEM, mdl[2]=WB.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic [4:0] s0;
    logic [4:0] s1;
    logic       u0;
    logic       u1;
  } instr_t;

  instr_t mdl [3];

  function automatic void compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic bit produces(input instr_t p, input logic [4:0] r);
    return p.valid && p.wr && (r != 5'd0) && (p.rd == r);
  endfunction

  function automatic logic [1:0] expect_fwd(input logic [4:0] r, input logic used);
    if (!used) return 2'd0;
    for (int j = 1; j < 3; j++) begin
      if (produces(mdl[j], r) && !(mdl[j].ld && j < LOAD_READY)) return 2'(j);
    end
    return 2'd0;
  endfunction

  function automatic bit expect_load_use();
    for (int j = 0; j < LOAD_READY - 1; j++) begin
      if (mdl[j].ld && ((id_src_used[0] && produces(mdl[j], id_src[4:0])) ||
                        (id_src_used[1] && produces(mdl[j], id_src[9:5])))) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Reference comparison on every cycle once the model has seen a reset.
  always @(negedge clk) begin : ref_check
    logic       es;
    logic       eb;
    logic [2:0] ef;
    logic [3:0] efw;
    if (model_ready) begin
      efw = {expect_fwd(mdl[0].s1, mdl[0].u1), expect_fwd(mdl[0].s0, mdl[0].u0)};
      if (reset) begin
        es = 1'b0; eb = 1'b0; ef = 3'b000; efw = 4'd0;
      end else if (hold) begin
        es = 1'b1; eb = 1'b0; ef = 3'b000;
      end else if (br_taken) begin
        es = 1'b0; eb = 1'b0; ef = 3'b111;
      end else begin
        es = expect_load_use(); eb = es; ef = 3'b000;
      end
      compare("model_stall_pc", stall_pc, es);
      compare("model_stall_ifid", stall_ifid, es);
      compare("model_bubble", bubble_idex, eb);
      compare("model_flush", flush, ef);
      compare("model_fwd_sel", fwd_sel, efw);
    end
  end

  // Advance the model pipeline on each clock edge.
  always @(posedge clk) begin : ref_update
    instr_t id_i;
    bit     squash_id;
    if (reset) begin
      for (int j = 0; j < 3; j++) mdl[j] = '0;
      model_ready = 1'b1;
    end else if (model_ready && !hold) begin
      squash_id = br_taken || expect_load_use();
      id_i = '{valid: id_valid, rd: id_rd, wr: id_reg_write, ld: id_mem_read,
               s0: id_src[4:0], s1: id_src[9:5], u0: id_src_used[0], u1: id_src_used[1]};
      mdl[2] = mdl[1];
      mdl[1] = br_taken ? instr_t'('0) : mdl[0];
      mdl[0] = squash_id ? instr_t'('0) : id_i;
    end
  end

  task automatic applyStimulus(input logic rst, input logic hld, input logic br, input logic vld,
                               input logic [4:0] rd, input logic wr, input logic ld,
                               input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
    @(posedge clk);
    #1;
    reset        = rst;
    hold         = hld;
    br_taken     = br;
    id_valid     = vld;
    id_rd        = rd;
    id_reg_write = wr;
    id_mem_read  = ld;
    id_src       = {s1, s0};
    id_src_used  = used;
  endtask

  task automatic issue(input logic [4:0] rd, input logic wr, input logic ld,
                       input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, rd, wr, ld, s0, s1, used);
  endtask

  task automatic nop();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
  endtask

  task automatic checkOutput(input string name, input logic es, input logic eb,
                             input logic [2:0] ef, input logic [3:0] efw);
    @(negedge clk);
    compare({name, "_stall_pc"}, stall_pc, es);
    compare({name, "_stall_ifid"}, stall_ifid, es);
    compare({name, "_bubble"}, bubble_idex, eb);
    compare({name, "_flush"}, flush, ef);
    compare({name, "_fwd_sel"}, fwd_sel, efw);
  endtask

  initial begin
    // Reset with busy inputs, then make sure nothing survives it.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 5'd3, 5'd5, 2'b11);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 5'd3, 5'd5, 2'b11);
    checkOutput("reset", 1'b0, 1'b0, 3'b000, 4'd0);
    issue(5'd4, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01);
    checkOutput("post_reset_id", 1'b0, 1'b0, 3'b000, 4'd0);
    nop();
    checkOutput("post_reset_fwd", 1'b0, 1'b0, 3'b000, 4'd0);

    // Forward distance: back-to-back, one gap, two gaps.
    issue(5'd3, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11);
    issue(5'd4, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01);
    nop();
    checkOutput("fwd_b2b", 1'b0, 1'b0, 3'b000, 4'b0001);
    issue(5'd3, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11);
    nop();
    issue(5'd4, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01);
    nop();
    checkOutput("fwd_gap1", 1'b0, 1'b0, 3'b000, 4'b0010);
    issue(5'd3, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11);
    nop();
    nop();
    issue(5'd4, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01);
    nop();
    checkOutput("fwd_gap2", 1'b0, 1'b0, 3'b000, 4'b0000);

    // Load-use: one stall cycle, then forwarding from WB.
    issue(5'd5, 1'b1, 1'b1, 5'd1, 5'd0, 2'b01);
    issue(5'd6, 1'b1, 1'b0, 5'd5, 5'd2, 2'b01);
    checkOutput("lu_stall", 1'b1, 1'b1, 3'b000, 4'd0);
    issue(5'd6, 1'b1, 1'b0, 5'd5, 5'd2, 2'b01);
    checkOutput("lu_release", 1'b0, 1'b0, 3'b000, 4'd0);
    nop();
    checkOutput("lu_fwd", 1'b0, 1'b0, 3'b000, 4'b0010);

    // Register 0 never creates a hazard or a forward.
    issue(5'd0, 1'b1, 1'b1, 5'd1, 5'd0, 2'b01);
    issue(5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b11);
    checkOutput("r0_nostall", 1'b0, 1'b0, 3'b000, 4'd0);
    nop();
    checkOutput("r0_fwd", 1'b0, 1'b0, 3'b000, 4'd0);

    // Branch in the same cycle as a load-use hazard.
    issue(5'd5, 1'b1, 1'b1, 5'd1, 5'd0, 2'b01);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd0, 2'b01);
    checkOutput("br_flush", 1'b0, 1'b0, 3'b111, 4'd0);
    issue(5'd8, 1'b1, 1'b0, 5'd6, 5'd5, 2'b11);
    checkOutput("br_after", 1'b0, 1'b0, 3'b000, 4'd0);
    nop();
    checkOutput("br_nofwd", 1'b0, 1'b0, 3'b000, 4'd0);

    // Hold for three cycles with a forward pending; the branch pulse inside is ignored.
    issue(5'd3, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11);
    issue(5'd4, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01);
    checkOutput("hold1", 1'b1, 1'b0, 3'b000, 4'b0001);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01);
    checkOutput("hold2_br", 1'b1, 1'b0, 3'b000, 4'b0001);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01);
    checkOutput("hold3", 1'b1, 1'b0, 3'b000, 4'b0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01);
    checkOutput("hold_release", 1'b0, 1'b0, 3'b000, 4'b0001);
    nop();
    checkOutput("hold_resume", 1'b0, 1'b0, 3'b000, 4'b0010);

    // Randomized traffic over a small register range, with occasional reset, hold and branch.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                    5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
    end
    nop();
    @(negedge clk);
    @(posedge clk);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
